// File: rtl/ysyx_lsu_pkg.sv
// rtl/ysyx_lsu_pkg.sv - shared size codes, state encoding and bus response constants for the LSU
package ysyx_lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [1:0] AXI_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_D,
        ST_WR_AW_W,
        ST_WR_B,
        ST_RESP
    } lsu_state_e;

    // Halfwords need an even address; words and unknown codes need a word-aligned address.
    function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            LSU_B, LSU_BU: mis = 1'b0;
            LSU_H, LSU_HU: mis = addr_lo[0];
            default:       mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_lsu_align.sv
// rtl/ysyx_lsu_align.sv - byte-lane strobe, store data shift and load data extension
module ysyx_lsu_align
    import ysyx_lsu_pkg::*;
#(
    parameter int BIT_W = 32
) (
    input  logic [1:0]         addr_lo,
    input  logic [2:0]         size,
    input  logic [BIT_W-1:0]   wdata,
    input  logic [BIT_W-1:0]   rdata,
    output logic [BIT_W/8-1:0] wstrb,
    output logic [BIT_W-1:0]   wdata_sh,
    output logic [BIT_W-1:0]   rdata_ext
);

    logic [BIT_W-1:0] rdata_sh;

    // Move data between the addressed byte lane and bit 0, then build strobe and extension per size.
    always_comb begin
        rdata_sh = rdata >> {addr_lo, 3'b000};
        wdata_sh = wdata << {addr_lo, 3'b000};
        case (size)
            LSU_B: begin
                wstrb     = 4'b0001 << addr_lo;
                rdata_ext = {{(BIT_W-8){rdata_sh[7]}}, rdata_sh[7:0]};
            end
            LSU_BU: begin
                wstrb     = 4'b0001 << addr_lo;
                rdata_ext = {{(BIT_W-8){1'b0}}, rdata_sh[7:0]};
            end
            LSU_H: begin
                wstrb     = 4'b0011 << addr_lo;
                rdata_ext = {{(BIT_W-16){rdata_sh[15]}}, rdata_sh[15:0]};
            end
            LSU_HU: begin
                wstrb     = 4'b0011 << addr_lo;
                rdata_ext = {{(BIT_W-16){1'b0}}, rdata_sh[15:0]};
            end
            default: begin
                wstrb     = 4'b1111;
                rdata_ext = rdata_sh;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_lsu.sv
// rtl/ysyx_lsu.sv - load/store unit: EXU request responder and AXI4-Lite data bus master
module ysyx_lsu
    import ysyx_lsu_pkg::*;
#(
    parameter int BIT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exu_avalid,
    input  logic [BIT_W-1:0]   exu_addr,
    input  logic               exu_ren,
    input  logic               exu_wen,
    input  logic [3:0]         exu_alu_op,
    input  logic [BIT_W-1:0]   exu_wdata,
    output logic [BIT_W-1:0]   lsu_rdata_o,
    output logic               lsu_rvalid_o,
    output logic               lsu_wready_o,
    output logic               lsu_err_o,
    output logic [BIT_W-1:0]   araddr,
    output logic               arvalid,
    input  logic               arready,
    input  logic [BIT_W-1:0]   rdata,
    input  logic [1:0]         rresp,
    input  logic               rvalid,
    output logic               rready,
    output logic [BIT_W-1:0]   awaddr,
    output logic               awvalid,
    input  logic               awready,
    output logic [BIT_W-1:0]   wdata,
    output logic [BIT_W/8-1:0] wstrb,
    output logic               wvalid,
    input  logic               wready,
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready
);

    lsu_state_e state_q, state_d;

    logic [BIT_W-1:0] addr_q;
    logic [BIT_W-1:0] wdata_q;
    logic [BIT_W-1:0] rdata_q;
    logic [2:0]       size_q;
    logic             load_q;
    logic             mis_q;
    logic             err_q;
    logic             aw_done_q;
    logic             w_done_q;

    logic             accept;
    logic             req_mis;
    logic [BIT_W-1:0] rdata_ext;
    logic             unused_op_bit;

    // Only func3 selects the access size; the top opcode bit carries no meaning here.
    assign unused_op_bit = exu_alu_op[3];

    assign accept  = (state_q == ST_IDLE) && exu_avalid && (exu_ren || exu_wen);
    assign req_mis = lsu_misaligned(exu_alu_op[2:0], exu_addr[1:0]);

    assign araddr      = {addr_q[BIT_W-1:2], 2'b00};
    assign awaddr      = {addr_q[BIT_W-1:2], 2'b00};
    assign lsu_rdata_o = rdata_q;

    ysyx_lsu_align #(.BIT_W(BIT_W)) u_align (
        .addr_lo   (addr_q[1:0]),
        .size      (size_q),
        .wdata     (wdata_q),
        .rdata     (rdata),
        .wstrb     (wstrb),
        .wdata_sh  (wdata),
        .rdata_ext (rdata_ext)
    );

    // State register; reset abandons any transaction in flight without a completion pulse.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state and bus/EXU handshake outputs; misaligned requests skip the bus entirely.
    always_comb begin
        state_d      = state_q;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        lsu_rvalid_o = 1'b0;
        lsu_wready_o = 1'b0;
        lsu_err_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = exu_ren ? ST_RD_A : ST_WR_AW_W;
            end
            ST_RD_A: begin
                if (mis_q) begin
                    state_d = ST_RESP;
                end else begin
                    arvalid = 1'b1;
                    if (arready) state_d = ST_RD_D;
                end
            end
            ST_RD_D: begin
                rready = 1'b1;
                if (rvalid) state_d = ST_RESP;
            end
            ST_WR_AW_W: begin
                if (mis_q) begin
                    state_d = ST_RESP;
                end else begin
                    awvalid = !aw_done_q;
                    wvalid  = !w_done_q;
                    if ((aw_done_q || awready) && (w_done_q || wready)) state_d = ST_WR_B;
                end
            end
            ST_WR_B: begin
                bready = 1'b1;
                if (bvalid) state_d = ST_RESP;
            end
            ST_RESP: begin
                lsu_rvalid_o = load_q;
                lsu_wready_o = !load_q;
                lsu_err_o    = err_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, per-channel write handshake tracking and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            size_q    <= LSU_W;
            load_q    <= 1'b0;
            mis_q     <= 1'b0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q    <= exu_addr;
                wdata_q   <= exu_wdata;
                size_q    <= exu_alu_op[2:0];
                load_q    <= exu_ren;
                mis_q     <= req_mis;
                err_q     <= req_mis;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                if (exu_ren && req_mis) rdata_q <= '0;
            end
            if (awvalid && awready) aw_done_q <= 1'b1;
            if (wvalid && wready)   w_done_q  <= 1'b1;
            if ((state_q == ST_RD_D) && rvalid) begin
                rdata_q <= rdata_ext;
                err_q   <= (rresp != AXI_OKAY);
            end
            if ((state_q == ST_WR_B) && bvalid) err_q <= (bresp != AXI_OKAY);
        end
    end

endmodule

// File: tb/tb_ysyx_lsu.sv
// tb/tb_ysyx_lsu.sv - directed self-checking bench for ysyx_lsu
module tb_ysyx_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_avalid;
    logic [31:0] exu_addr;
    logic        exu_ren;
    logic        exu_wen;
    logic [3:0]  exu_alu_op;
    logic [31:0] exu_wdata;
    logic [31:0] lsu_rdata_o;
    logic        lsu_rvalid_o;
    logic        lsu_wready_o;
    logic        lsu_err_o;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks = 0;
    int errors = 0;

    ysyx_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .exu_avalid   (exu_avalid),
        .exu_addr     (exu_addr),
        .exu_ren      (exu_ren),
        .exu_wen      (exu_wen),
        .exu_alu_op   (exu_alu_op),
        .exu_wdata    (exu_wdata),
        .lsu_rdata_o  (lsu_rdata_o),
        .lsu_rvalid_o (lsu_rvalid_o),
        .lsu_wready_o (lsu_wready_o),
        .lsu_err_o    (lsu_err_o),
        .araddr       (araddr),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .rready       (rready),
        .awaddr       (awaddr),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [3:0] op,
                           input logic [31:0] word, input logic [1:0] resp,
                           input logic [31:0] exp_d, input logic exp_err);
        exu_avalid = 1'b1; exu_ren = 1'b1; exu_wen = 1'b0; exu_addr = a; exu_alu_op = op;
        tick();
        check({tag, "_arvalid"}, 32'(arvalid), 32'd1);
        check({tag, "_araddr"}, araddr, {a[31:2], 2'b00});
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check({tag, "_arvalid_drop"}, 32'(arvalid), 32'd0);
        check({tag, "_rready"}, 32'(rready), 32'd1);
        check({tag, "_no_early_rvalid"}, 32'(lsu_rvalid_o), 32'd0);
        rvalid = 1'b1; rdata = word; rresp = resp;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        check({tag, "_rvalid_o"}, 32'(lsu_rvalid_o), 32'd1);
        check({tag, "_rdata_o"}, lsu_rdata_o, exp_d);
        check({tag, "_err_o"}, 32'(lsu_err_o), 32'(exp_err));
        check({tag, "_wready_o_quiet"}, 32'(lsu_wready_o), 32'd0);
        exu_avalid = 1'b0; exu_ren = 1'b0;
        tick();
        check({tag, "_rvalid_o_end"}, 32'(lsu_rvalid_o), 32'd0);
        check({tag, "_rdata_hold"}, lsu_rdata_o, exp_d);
    endtask

    task automatic do_store(input string tag, input logic [31:0] a, input logic [3:0] op,
                            input logic [31:0] d, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wd, input int aw_delay);
        bit aw_t = 0;
        bit w_t = 0;
        exu_avalid = 1'b1; exu_ren = 1'b0; exu_wen = 1'b1; exu_addr = a; exu_alu_op = op;
        exu_wdata = d;
        tick();
        check({tag, "_awvalid"}, 32'(awvalid), 32'd1);
        check({tag, "_wvalid"}, 32'(wvalid), 32'd1);
        check({tag, "_wstrb"}, 32'(wstrb), 32'(exp_strb));
        check({tag, "_wdata"}, wdata, exp_wd);
        for (int cyc = 0; cyc < 20 && !(aw_t && w_t); cyc++) begin
            awready = (cyc >= aw_delay);
            wready  = 1'b1;
            if (awvalid && awready) aw_t = 1;
            if (wvalid && wready)   w_t = 1;
            tick();
            awready = 1'b0; wready = 1'b0;
            if (!(aw_t && w_t)) begin
                check({tag, "_awvalid_hold"}, 32'(awvalid), 32'(!aw_t));
                check({tag, "_wvalid_state"}, 32'(wvalid), 32'(!w_t));
            end
        end
        check({tag, "_aw_w_done"}, 32'(aw_t && w_t), 32'd1);
        check({tag, "_bready"}, 32'(bready), 32'd1);
        check({tag, "_no_early_wready"}, 32'(lsu_wready_o), 32'd0);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        check({tag, "_wready_o"}, 32'(lsu_wready_o), 32'd1);
        check({tag, "_err_o"}, 32'(lsu_err_o), 32'd0);
        check({tag, "_rvalid_o_quiet"}, 32'(lsu_rvalid_o), 32'd0);
        exu_avalid = 1'b0; exu_wen = 1'b0;
        tick();
        check({tag, "_wready_o_end"}, 32'(lsu_wready_o), 32'd0);
    endtask

    task automatic do_misaligned(input string tag, input logic [31:0] a, input logic [3:0] op,
                                 input logic is_load);
        exu_avalid = 1'b1; exu_ren = is_load; exu_wen = !is_load; exu_addr = a; exu_alu_op = op;
        exu_wdata = 32'h1234_5678;
        tick();
        check({tag, "_no_bus"}, 32'(arvalid | awvalid | wvalid), 32'd0);
        check({tag, "_no_early_pulse"}, 32'(lsu_rvalid_o | lsu_wready_o), 32'd0);
        tick();
        check({tag, "_no_bus2"}, 32'(arvalid | awvalid | wvalid), 32'd0);
        check({tag, "_rvalid_o"}, 32'(lsu_rvalid_o), 32'(is_load));
        check({tag, "_wready_o"}, 32'(lsu_wready_o), 32'(!is_load));
        check({tag, "_err_o"}, 32'(lsu_err_o), 32'd1);
        if (is_load) check({tag, "_rdata_zero"}, lsu_rdata_o, 32'h0);
        exu_avalid = 1'b0; exu_ren = 1'b0; exu_wen = 1'b0;
        tick();
        check({tag, "_pulse_end"}, 32'(lsu_rvalid_o | lsu_wready_o | lsu_err_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        exu_avalid = 1'b0; exu_addr = '0; exu_ren = 1'b0; exu_wen = 1'b0;
        exu_alu_op = 4'b0010; exu_wdata = '0;
        arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        repeat (3) tick();
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid", 32'(wvalid), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_bready", 32'(bready), 32'd0);
        check("rst_pulses", 32'(lsu_rvalid_o | lsu_wready_o | lsu_err_o), 32'd0);
        check("rst_rdata_o", lsu_rdata_o, 32'h0);
        rst = 1'b0;
        tick();

        do_load("lb",   32'h8000_0003, 4'b0000, 32'h80AA_5511, 2'b00, 32'hFFFF_FF80, 1'b0);
        do_load("lhu",  32'h8000_0002, 4'b0101, 32'hBEEF_1234, 2'b00, 32'h0000_BEEF, 1'b0);
        do_load("lh",   32'h8000_0002, 4'b0001, 32'hBEEF_1234, 2'b00, 32'hFFFF_BEEF, 1'b0);
        do_load("lbu",  32'h8000_0001, 4'b0100, 32'h80AA_5511, 2'b00, 32'h0000_0055, 1'b0);
        do_load("lw",   32'h8000_0004, 4'b0010, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0);
        do_load("lwerr", 32'h8000_0008, 4'b0010, 32'hCAFE_F00D, 2'b10, 32'hCAFE_F00D, 1'b1);

        do_store("sb", 32'h8000_0001, 4'b0000, 32'h0000_00A5, 4'b0010, 32'h0000_A500, 0);
        check("sb_rdata_hold", lsu_rdata_o, 32'hCAFE_F00D);
        do_store("sh", 32'h8000_0002, 4'b0001, 32'h1234_ABCD, 4'b1100, 32'hABCD_0000, 0);
        do_store("sw_awdly", 32'h8000_0008, 4'b0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 3);

        do_misaligned("lw_mis", 32'h8000_0002, 4'b0010, 1'b1);
        do_misaligned("sh_mis", 32'h8000_0001, 4'b0001, 1'b0);

        exu_avalid = 1'b1; exu_ren = 1'b1; exu_wen = 1'b0; exu_addr = 32'h8000_0010;
        exu_alu_op = 4'b0010;
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("rstmid_rready_before", 32'(rready), 32'd1);
        rst = 1'b1;
        tick();
        check("rstmid_rready", 32'(rready), 32'd0);
        check("rstmid_arvalid", 32'(arvalid), 32'd0);
        check("rstmid_rvalid_o", 32'(lsu_rvalid_o), 32'd0);
        rst = 1'b0; exu_avalid = 1'b0; exu_ren = 1'b0;
        tick();
        check("rstmid_rvalid_o_after", 32'(lsu_rvalid_o), 32'd0);
        check("rstmid_rready_after", 32'(rready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
